pos_cache_motion_update_arbiter: RTL and testbench
==================================================

Name: pos_cache_motion_update_arbiter

Overview:
- Sequences one motion-update pass for the array of double-buffered position caches.
- Collects updated particles from NUM_REQ motion-update units, arbitrates them round-robin, and broadcasts one particle per cycle (data + destination cell) to every cache.
- Owns the caches' motion_update_enable window, then waits out the caches' count-write and buffer-swap before signalling done.

Parameters:
- DATA_WIDTH, 32, width of one position component (broadcast word is 3*DATA_WIDTH, {posz,posy,posx}).
- CELL_ID_WIDTH, 4, width of one cell coordinate (dst word is 3*CELL_ID_WIDTH, {cell_x,cell_y,cell_z}).
- NUM_REQ, 4, number of motion-update requesters (2..16).
- DRAIN_CYCLES, 3, cycles held after motion_update_enable falls before done (covers cache WRITE_PARTICLE_NUM + MOTION_UPDATE_DONE + 1 margin).
- CNT_WIDTH, 16, width of broadcast particle counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; begins a pass (ignored unless IDLE)
- req_valid  in  NUM_REQ  requester i presents a particle
- req_data  in  NUM_REQ*3*DATA_WIDTH  slice i = particle position of requester i
- req_dst_cell  in  NUM_REQ*3*CELL_ID_WIDTH  slice i = destination cell of requester i
- req_done  in  NUM_REQ  requester i has no more particles this pass (level or pulse; sticky internally)
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- motion_update_enable  out  1  to all caches
- out_data  out  3*DATA_WIDTH  broadcast position
- out_data_dst_cell  out  3*CELL_ID_WIDTH  broadcast destination
- out_data_valid  out  1  broadcast qualifier
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse at end of pass
- particle_count  out  CNT_WIDTH  particles broadcast in the current/last pass
- protocol_err  out  1  sticky; req_valid seen from a requester already marked done

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0, done flags cleared, rr pointer 0, particle_count 0, protocol_err 0.
- States:
  - IDLE: req_ready=0, enable=0. On start: clear done flags, particle_count, protocol_err; enable<=1, busy<=1; go BCAST.
  - BCAST: enable=1.
    - req_ready is combinational one-hot: the first i with req_valid[i] & ~done_flag[i], searching from rr pointer upward with wrap; all zero if none.
    - On transfer from i: out_data, out_data_dst_cell, out_data_valid<=1 next cycle (1-cycle latency); rr pointer<=(i+1) mod NUM_REQ; particle_count++ (saturates at all-ones).
    - With no transfer, out_data_valid<=0 and out_data/out_data_dst_cell<=0.
    - done_flag[i] |= req_done[i] each cycle. A particle presented with req_done in the same cycle is still transferred.
    - When all done flags (including this cycle's req_done) are set and no transfer occurs this cycle: enable<=0; go DRAIN.
    - The final broadcast is therefore always seen with enable=1.
  - DRAIN: enable=0, out_data_valid=0, req_ready=0. Counts DRAIN_CYCLES cycles, then done<=1 (one cycle), busy<=0, go IDLE.
- Boundary conditions:
  - start in a non-IDLE state: ignored.
  - A pass with zero particles (all req_done at start) still runs enable high ≥1 cycle, so the caches write count 0 and swap.
  - req_valid on a done requester: never granted; protocol_err<=1.
- Timing: one broadcast per cycle maximum, no bubbles under continuous valid.
- Fairness: no requester waits more than NUM_REQ-1 grants.
- Reset mid-pass: block returns to IDLE immediately. The caches are not reset by this block; the system must reset them together.

Test Plan:
- Reset, then start with all req_done=1 and no valid -> enable high exactly 1 cycle, no out_data_valid, done pulses DRAIN_CYCLES+1 cycles after enable falls, particle_count=0.
- NUM_REQ=4, each requester holds valid with 3 particles (dst {1,2,3} etc.), done after the last -> grant order 0,1,2,3,0,1,2,3,…; 12 consecutive out_data_valid cycles; particle_count=12; each cache under test reads address 0 = its share.
- Requester 2 alone valid continuously (5 particles) while others are done -> 5 back-to-back broadcasts, req_ready=4'b0100 each cycle, then enable drops the cycle after the last valid.
- Last particle presented with req_done=1 in the same cycle -> particle transferred and broadcast while enable=1; enable falls the following cycle.
- Requester 1 asserts valid after its done -> never granted, protocol_err=1, pass still completes.
- rst asserted low mid-BCAST -> all outputs 0 immediately; a later start runs a clean pass with particle_count restarting at 0.

Source files
------------

// File: rtl/pos_cache_motion_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pos_cache_motion_update_arbiter
// Purpose  : Round-robin collection of motion-updated particles and broadcast
//            to all position caches; owns the motion_update_enable window.
// Revision : 1.0
// ============================================================================
module pos_cache_motion_update_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int CELL_ID_WIDTH = 4,
    parameter int NUM_REQ       = 4,
    parameter int DRAIN_CYCLES  = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*3*DATA_WIDTH-1:0]      req_data,
    input  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0]   req_dst_cell,
    input  logic [NUM_REQ-1:0]                   req_done,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]              out_data,
    output logic [3*CELL_ID_WIDTH-1:0]           out_data_dst_cell,
    output logic                                 out_data_valid,
    output logic                                 busy,
    output logic                                 done,
    output logic [CNT_WIDTH-1:0]                 particle_count,
    output logic                                 protocol_err
);

    localparam int PW    = 3 * DATA_WIDTH;
    localparam int CW    = 3 * CELL_ID_WIDTH;
    localparam int IDX_W = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);
    localparam int DRN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [IDX_W:0]   C_NUM_REQ    = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [DRN_W-1:0] C_DRAIN_LAST = DRN_W'(DRAIN_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BCAST = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           r_state;
    logic [NUM_REQ-1:0]   r_done_flag;
    logic [IDX_W-1:0]     r_rr;
    logic [DRN_W-1:0]     r_drain_cnt;
    logic                 r_en;
    logic                 r_busy;
    logic                 r_done_pulse;
    logic                 r_perr;
    logic [CNT_WIDTH-1:0] r_count;
    logic [PW-1:0]        r_out_data;
    logic [CW-1:0]        r_out_dst;
    logic                 r_out_valid;

    logic [NUM_REQ-1:0]   w_eligible;
    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_grant_idx;
    logic [IDX_W:0]       w_idx;
    logic                 w_found;
    logic [NUM_REQ-1:0]   w_done_next;
    logic                 w_all_done;
    logic [IDX_W-1:0]     w_rr_next;
    logic [PW-1:0]        w_sel_data;
    logic [CW-1:0]        w_sel_dst;

    // A requester already marked done is never eligible; one presenting its
    // last particle together with req_done is, since the flag lags a cycle.
    assign w_eligible = req_valid & ~r_done_flag;

    // Round-robin search starting at r_rr, wrapping modulo NUM_REQ.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        if (r_state == ST_BCAST) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx = {1'b0, r_rr} + (IDX_W+1)'(k);
                if (w_idx >= C_NUM_REQ) begin
                    w_idx = w_idx - C_NUM_REQ;
                end
                if (!w_found && w_eligible[w_idx[IDX_W-1:0]]) begin
                    w_found     = 1'b1;
                    w_grant_idx = w_idx[IDX_W-1:0];
                end
            end
        end
        if (w_found) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign w_done_next = r_done_flag | req_done;
    assign w_all_done  = &w_done_next;
    assign w_rr_next   = (w_grant_idx == C_LAST_IDX) ? '0 : w_grant_idx + IDX_W'(1);
    assign w_sel_data  = req_data[int'(w_grant_idx)*PW +: PW];
    assign w_sel_dst   = req_dst_cell[int'(w_grant_idx)*CW +: CW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_done_flag  <= '0;
            r_rr         <= '0;
            r_drain_cnt  <= '0;
            r_en         <= 1'b0;
            r_busy       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_perr       <= 1'b0;
            r_count      <= '0;
            r_out_data   <= '0;
            r_out_dst    <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_dst    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_done_flag <= '0;
                        r_count     <= '0;
                        r_perr      <= 1'b0;
                        r_en        <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_BCAST;
                    end
                end
                ST_BCAST: begin
                    r_done_flag <= w_done_next;
                    if (|(req_valid & r_done_flag)) begin
                        r_perr <= 1'b1;
                    end
                    if (w_found) begin
                        r_out_data  <= w_sel_data;
                        r_out_dst   <= w_sel_dst;
                        r_out_valid <= 1'b1;
                        r_rr        <= w_rr_next;
                        if (r_count != '1) begin
                            r_count <= r_count + CNT_WIDTH'(1);
                        end
                    end else if (w_all_done) begin
                        // Leaving only on a transfer-free cycle guarantees the
                        // final broadcast is seen with enable still high.
                        r_en        <= 1'b0;
                        r_drain_cnt <= '0;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == C_DRAIN_LAST) begin
                        r_done_pulse <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DRN_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready            = w_grant;
    assign motion_update_enable = r_en;
    assign out_data             = r_out_data;
    assign out_data_dst_cell    = r_out_dst;
    assign out_data_valid       = r_out_valid;
    assign busy                 = r_busy;
    assign done                 = r_done_pulse;
    assign particle_count       = r_count;
    assign protocol_err         = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_pos_cache_motion_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pos_cache_motion_update_arbiter
// Purpose  : Directed, table-driven bench for pos_cache_motion_update_arbiter.
// Revision : 1.0
// ============================================================================
module tb_pos_cache_motion_update_arbiter;

    localparam int DW = 32;
    localparam int CI = 4;
    localparam int NR = 4;
    localparam int PW = 3 * DW;
    localparam int CW = 3 * CI;

    logic              clk;
    logic              rst;
    logic              start;
    logic [NR-1:0]     req_valid;
    logic [NR*PW-1:0]  req_data;
    logic [NR*CW-1:0]  req_dst_cell;
    logic [NR-1:0]     req_done;
    logic [NR-1:0]     req_ready;
    logic              motion_update_enable;
    logic [PW-1:0]     out_data;
    logic [CW-1:0]     out_data_dst_cell;
    logic              out_data_valid;
    logic              busy;
    logic              done;
    logic [15:0]       particle_count;
    logic              protocol_err;

    pos_cache_motion_update_arbiter #(
        .DATA_WIDTH(DW), .CELL_ID_WIDTH(CI), .NUM_REQ(NR),
        .DRAIN_CYCLES(3), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .req_valid(req_valid), .req_data(req_data), .req_dst_cell(req_dst_cell),
        .req_done(req_done), .req_ready(req_ready),
        .motion_update_enable(motion_update_enable),
        .out_data(out_data), .out_data_dst_cell(out_data_dst_cell),
        .out_data_valid(out_data_valid), .busy(busy), .done(done),
        .particle_count(particle_count), .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row = one clock cycle: inputs applied, outputs visible in that cycle.
    typedef struct packed {
        logic          start;
        logic [NR-1:0] valid;
        logic [NR-1:0] rdone;
        logic [NR-1:0] exp_ready;
        logic          exp_en;
        logic          exp_ov;
        logic          exp_busy;
        logic          exp_done;
    } vec_t;

    vec_t             tbl[$];
    logic [PW+CW-1:0] exp_q[$];
    int               seq[NR];
    int               errors = 0;
    int               checks = 0;

    function automatic logic [PW-1:0] exp_pos(input int i, input int k);
        return {32'(k + 1), 32'(i), 32'hC0DE_0000 + 32'(i * 256 + k)};
    endfunction

    function automatic logic [CW-1:0] exp_dst(input int i, input int k);
        return {4'(i + 1), 4'(k), 4'hA};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic [3:0] v, input logic [3:0] d,
                       input logic [3:0] r, input logic en, input logic ov,
                       input logic b, input logic dn);
        tbl.push_back('{s, v, d, r, en, ov, b, dn});
    endtask

    task automatic add_drain_done();
        repeat (4) add(1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drive_data();
        for (int i = 0; i < NR; i++) begin
            req_data[i*PW +: PW]     = exp_pos(i, seq[i]);
            req_dst_cell[i*CW +: CW] = exp_dst(i, seq[i]);
        end
    endtask

    task automatic run_row(input vec_t v, input int n);
        logic [PW+CW-1:0] e;
        start     = v.start;
        req_valid = v.valid;
        req_done  = v.rdone;
        drive_data();
        #2;
        chk($sformatf("ready[%0d]", n), req_ready, v.exp_ready);
        chk($sformatf("enable[%0d]", n), motion_update_enable, v.exp_en);
        chk($sformatf("out_valid[%0d]", n), out_data_valid, v.exp_ov);
        chk($sformatf("busy[%0d]", n), busy, v.exp_busy);
        chk($sformatf("done[%0d]", n), done, v.exp_done);
        if (v.exp_ov) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bcast_underflow[%0d]: got broadcast expected none queued", n);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("out_data[%0d]", n), out_data, e[PW+CW-1:CW]);
                chk($sformatf("out_dst[%0d]", n), out_data_dst_cell, e[CW-1:0]);
            end
        end else begin
            chk($sformatf("out_zero[%0d]", n), {out_data, out_data_dst_cell}, '0);
        end
        for (int i = 0; i < NR; i++) begin
            if (v.valid[i] && v.exp_ready[i]) begin
                exp_q.push_back({exp_pos(i, seq[i]), exp_dst(i, seq[i])});
                seq[i]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int n = lo; n < hi; n++) run_row(tbl[n], n);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_enable"}, motion_update_enable, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_ov"}, out_data_valid, 1'b0);
        chk({tag, "_data"}, {out_data, out_data_dst_cell}, '0);
        chk({tag, "_ready"}, req_ready, '0);
        chk({tag, "_count"}, particle_count, 16'd0);
        chk({tag, "_perr"}, protocol_err, 1'b0);
    endtask

    int a_lo, b_lo, c_lo, d_lo, e_lo, f_lo, g_lo, g_hi;

    initial begin
        for (int i = 0; i < NR; i++) seq[i] = 0;

        // A: zero-particle pass
        a_lo = tbl.size();
        add(1'b1, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        add_drain_done();
        add(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        // B: four requesters, three particles each
        b_lo = tbl.size();
        add(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++)
            add(1'b0, 4'hF, 4'h0, 4'(1 << (k % 4)), 1'b1, (k != 0), 1'b1, 1'b0);
        add(1'b0, 4'hE, 4'h1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'hC, 4'h3, 4'h4, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'h8, 4'h7, 4'h8, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        add_drain_done();
        // C: requester 2 alone, five back-to-back
        c_lo = tbl.size();
        add(1'b1, 4'h0, 4'hB, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++)
            add(1'b0, 4'h4, 4'hB, 4'h4, 1'b1, (k != 0), 1'b1, 1'b0);
        add(1'b0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        add_drain_done();
        // D: last particle together with req_done
        d_lo = tbl.size();
        add(1'b1, 4'h0, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'h1, 4'hE, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'h1, 4'hF, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        add_drain_done();
        // E: requester 1 valid after done
        e_lo = tbl.size();
        add(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'h2, 4'h2, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'h2, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        add_drain_done();
        // F: pass to be interrupted by reset
        f_lo = tbl.size();
        add(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'hF, 4'h0, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'hF, 4'h0, 4'h8, 1'b1, 1'b1, 1'b1, 1'b0);
        // G: clean single-particle pass after reset
        g_lo = tbl.size();
        add(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 4'h8, 4'h7, 4'h8, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        add_drain_done();
        g_hi = tbl.size();

        rst = 1'b1; start = 1'b0; req_valid = '0; req_done = '0;
        req_data = '0; req_dst_cell = '0;
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        run_rows(a_lo, b_lo);
        chk("A_count", particle_count, 16'd0);
        chk("A_perr", protocol_err, 1'b0);
        run_rows(b_lo, c_lo);
        chk("B_count", particle_count, 16'd12);
        run_rows(c_lo, d_lo);
        chk("C_count", particle_count, 16'd5);
        run_rows(d_lo, e_lo);
        chk("D_count", particle_count, 16'd2);
        chk("D_perr", protocol_err, 1'b0);
        run_rows(e_lo, f_lo);
        chk("E_count", particle_count, 16'd1);
        chk("E_perr", protocol_err, 1'b1);

        run_rows(f_lo, g_lo);
        chk("F_count_pre", particle_count, 16'd2);
        req_valid = '0;
        #2 rst = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_q.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        run_rows(g_lo, g_hi);
        chk("G_count", particle_count, 16'd1);
        chk("G_perr", protocol_err, 1'b0);
        chk("G_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
